// File: rtl/befehlsabruf.sv
// Instruction fetch stage of the Hans core: owns the PC, fetches words over a request/ready
// handshake and presents them to the decoder. Optional prefetch buffer: BEFEHLSABRUF_VORHOLEN_EN.
module befehlsabruf #(
  parameter logic [31:0] StartAdresse = 32'h0000_0000
) (
  input  logic        Clock,
  input  logic        Reset,
  output logic [31:0] SpeicherAdresse,
  output logic        SpeicherLesen,
  input  logic [31:0] SpeicherDaten,
  input  logic        SpeicherBereit,
  output logic [31:0] Instruktion,
  output logic        DekodierSignal,
  input  logic        Weiter,
  input  logic        SprungAktiv,
  input  logic        RelativerSprung,
  input  logic        AbsoluterSprung,
  input  logic [25:0] SprungOffset,
  input  logic [31:0] RegisterWert,
  output logic [31:0] BefehlsZaehler,
  output logic [31:0] RueckkehrAdresse
);

  localparam int unsigned AdrBreite = 32;
  localparam int unsigned OffBreite = 26;

  typedef enum logic [1:0] {
    HOLEN     = 2'd0,
    AUSGABE   = 2'd1,
    WARTEN    = 2'd2,
    VERWERFEN = 2'd3
  } zustand_e;

  zustand_e zustand_q, zustand_d;

  logic [AdrBreite-1:0] pc_q, pc_d;
  logic [AdrBreite-1:0] instr_q, instr_d;
  logic [AdrBreite-1:0] bz_q, bz_d;
  logic [AdrBreite-1:0] pc_plus1;
  logic [AdrBreite-1:0] sprung_ziel;
  logic [AdrBreite-1:0] offset_sext;
  logic                 sprung_gueltig;
  logic                 lesen_c;

`ifdef BEFEHLSABRUF_VORHOLEN_EN
  logic [AdrBreite-1:0] puffer_daten_q, puffer_daten_d;
  logic                 puffer_gueltig_q, puffer_gueltig_d;
  logic [AdrBreite-1:0] ziel_q, ziel_d;
`endif

  assign pc_plus1    = pc_q + AdrBreite'(1);
  assign offset_sext = {{(AdrBreite-OffBreite){SprungOffset[OffBreite-1]}}, SprungOffset};
  // A jump needs exactly one qualifier; anything else behaves like Weiter.
  assign sprung_gueltig = SprungAktiv && (RelativerSprung ^ AbsoluterSprung);
  assign sprung_ziel    = RelativerSprung ? (bz_q + offset_sext) : RegisterWert;

  // State register
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand_q <= HOLEN;
    end else begin
      zustand_q <= zustand_d;
    end
  end

  // Next-state and datapath update
  always_comb begin
    zustand_d = zustand_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    bz_d      = bz_q;
`ifdef BEFEHLSABRUF_VORHOLEN_EN
    puffer_daten_d   = puffer_daten_q;
    puffer_gueltig_d = puffer_gueltig_q;
    ziel_d           = ziel_q;
`endif
    case (zustand_q)
      HOLEN: begin
        if (SpeicherBereit) begin
          instr_d   = SpeicherDaten;
          zustand_d = AUSGABE;
        end
      end
      AUSGABE: begin
        bz_d      = pc_q;
        zustand_d = WARTEN;
      end
      WARTEN: begin
`ifdef BEFEHLSABRUF_VORHOLEN_EN
        // Speculative read of pc+1 is active whenever the buffer is empty.
        if (sprung_gueltig) begin
          puffer_gueltig_d = 1'b0;
          if (!puffer_gueltig_q && !SpeicherBereit) begin
            ziel_d    = sprung_ziel;
            zustand_d = VERWERFEN;
          end else begin
            pc_d      = sprung_ziel;
            zustand_d = HOLEN;
          end
        end else if (Weiter || SprungAktiv) begin
          pc_d = pc_plus1;
          if (puffer_gueltig_q) begin
            instr_d          = puffer_daten_q;
            puffer_gueltig_d = 1'b0;
            zustand_d        = AUSGABE;
          end else if (SpeicherBereit) begin
            instr_d   = SpeicherDaten;
            zustand_d = AUSGABE;
          end else begin
            zustand_d = HOLEN;
          end
        end else if (!puffer_gueltig_q && SpeicherBereit) begin
          puffer_daten_d   = SpeicherDaten;
          puffer_gueltig_d = 1'b1;
        end
`else
        if (sprung_gueltig) begin
          pc_d      = sprung_ziel;
          zustand_d = HOLEN;
        end else if (Weiter || SprungAktiv) begin
          pc_d      = pc_plus1;
          zustand_d = HOLEN;
        end
`endif
      end
`ifdef BEFEHLSABRUF_VORHOLEN_EN
      VERWERFEN: begin
        if (SpeicherBereit) begin
          pc_d      = ziel_q;
          zustand_d = HOLEN;
        end
      end
`endif
      default: begin
        zustand_d = HOLEN;
      end
    endcase
  end

  // Memory request and decoder strobe
  always_comb begin
    lesen_c         = 1'b0;
    SpeicherAdresse = pc_q;
    DekodierSignal  = 1'b0;
    case (zustand_q)
      HOLEN: begin
        lesen_c = 1'b1;
      end
      AUSGABE: begin
        DekodierSignal = 1'b1;
      end
`ifdef BEFEHLSABRUF_VORHOLEN_EN
      WARTEN: begin
        lesen_c         = !puffer_gueltig_q;
        SpeicherAdresse = pc_plus1;
      end
      VERWERFEN: begin
        lesen_c         = 1'b1;
        SpeicherAdresse = pc_plus1;
      end
`endif
      default: begin
      end
    endcase
    SpeicherLesen = lesen_c && !Reset;
  end

  // Datapath registers
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pc_q    <= StartAdresse;
      instr_q <= '0;
      bz_q    <= StartAdresse;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      bz_q    <= bz_d;
    end
  end

`ifdef BEFEHLSABRUF_VORHOLEN_EN
  always_ff @(posedge Clock) begin
    if (Reset) begin
      puffer_daten_q   <= '0;
      puffer_gueltig_q <= 1'b0;
      ziel_q           <= '0;
    end else begin
      puffer_daten_q   <= puffer_daten_d;
      puffer_gueltig_q <= puffer_gueltig_d;
      ziel_q           <= ziel_d;
    end
  end
`endif

  assign Instruktion      = instr_q;
  assign BefehlsZaehler   = bz_q;
  assign RueckkehrAdresse = bz_q + AdrBreite'(1);

endmodule

// File: tb/tb_befehlsabruf.sv
// Bench for befehlsabruf: memory responder with configurable wait states, architectural
// PC model and handshake monitor.
module tb_befehlsabruf;

  localparam logic [31:0] START = 32'h0000_0000;

  logic        Clock = 1'b0;
  logic        Reset = 1'b1;
  logic [31:0] SpeicherAdresse;
  logic        SpeicherLesen;
  logic [31:0] SpeicherDaten;
  logic        SpeicherBereit;
  logic [31:0] Instruktion;
  logic        DekodierSignal;
  logic        Weiter = 1'b0;
  logic        SprungAktiv = 1'b0;
  logic        RelativerSprung = 1'b0;
  logic        AbsoluterSprung = 1'b0;
  logic [25:0] SprungOffset = '0;
  logic [31:0] RegisterWert = '0;
  logic [31:0] BefehlsZaehler;
  logic [31:0] RueckkehrAdresse;

  int errors = 0;
  int checks = 0;
  int wait_cfg = 0;
  int wcnt = 0;

  befehlsabruf #(.StartAdresse(START)) dut (
    .Clock            (Clock),
    .Reset            (Reset),
    .SpeicherAdresse  (SpeicherAdresse),
    .SpeicherLesen    (SpeicherLesen),
    .SpeicherDaten    (SpeicherDaten),
    .SpeicherBereit   (SpeicherBereit),
    .Instruktion      (Instruktion),
    .DekodierSignal   (DekodierSignal),
    .Weiter           (Weiter),
    .SprungAktiv      (SprungAktiv),
    .RelativerSprung  (RelativerSprung),
    .AbsoluterSprung  (AbsoluterSprung),
    .SprungOffset     (SprungOffset),
    .RegisterWert     (RegisterWert),
    .BefehlsZaehler   (BefehlsZaehler),
    .RueckkehrAdresse (RueckkehrAdresse)
  );

  always #5 Clock = ~Clock;

  // Memory contents as a pure function of the word address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd3) return 32'h0400_0001 + a;
    return (a * 32'h9E37_79B1) ^ 32'hC3A5_5A3C;
  endfunction

  always_comb begin
    SpeicherBereit = SpeicherLesen && (wcnt >= wait_cfg);
    SpeicherDaten  = SpeicherBereit ? mem_word(SpeicherAdresse) : 32'hDEAD_BEEF;
  end

  always @(posedge Clock) wcnt <= (SpeicherLesen && !SpeicherBereit) ? wcnt + 1 : 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Open requests must stay up with a stable address until ready (reset excepted).
  logic        prev_lesen = 1'b0;
  logic        prev_bereit = 1'b0;
  logic        prev_reset = 1'b1;
  logic [31:0] prev_addr = '0;
  always @(posedge Clock) begin
    #3;
    if (prev_lesen && !prev_bereit && !prev_reset && !Reset) begin
      chk("anfrage_gehalten", 32'(SpeicherLesen), 32'd1);
      chk("adresse_stabil", SpeicherAdresse, prev_addr);
    end
    prev_lesen  = SpeicherLesen;
    prev_bereit = SpeicherBereit;
    prev_reset  = Reset;
    prev_addr   = SpeicherAdresse;
  end

  function automatic int lat_seq(input int w);
`ifdef BEFEHLSABRUF_VORHOLEN_EN
    return (w == 0) ? 1 : 0;
`else
    return 2 + w;
`endif
  endfunction

  function automatic int lat_jmp(input int w);
`ifdef BEFEHLSABRUF_VORHOLEN_EN
    return (w == 0) ? 2 : 0;
`else
    return 2 + w;
`endif
  endfunction

  function automatic int les_cnt(input int w);
`ifdef BEFEHLSABRUF_VORHOLEN_EN
    return -1 + 0 * w;
`else
    return 1 + w;
`endif
  endfunction

  // Drive one command for exactly one sampling edge.
  task automatic befehl(input bit w, input bit s, input bit r, input bit a,
                        input logic [25:0] off, input logic [31:0] regw);
    Weiter = w; SprungAktiv = s; RelativerSprung = r; AbsoluterSprung = a;
    SprungOffset = off; RegisterWert = regw;
    @(posedge Clock);
    #1;
    Weiter = 1'b0; SprungAktiv = 1'b0; RelativerSprung = 1'b0; AbsoluterSprung = 1'b0;
  endtask

  // Wait for the next decode strobe and check word, latency, fetch cycles and PC outputs.
  task automatic wait_decode(input logic [31:0] exp_pc, input int exp_lat,
                             input int exp_lesen, input bit stoer);
    int n = 0;
    int lesen_n = 0;
    bit seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge Clock);
      n++;
      if (DekodierSignal === 1'b1) begin
        seen = 1'b1;
      end else begin
        if (SpeicherLesen === 1'b1) lesen_n++;
        if (n == 1 && exp_lesen >= 0) begin
          chk("abruf_lesen", 32'(SpeicherLesen), 32'd1);
          chk("abruf_adresse", SpeicherAdresse, exp_pc);
        end
        if (stoer) begin
          Weiter = 1'b1; SprungAktiv = 1'($urandom_range(0, 1));
          AbsoluterSprung = 1'b1; RegisterWert = 32'hBAD0_0000;
        end
      end
      if (seen) begin
        Weiter = 1'b0; SprungAktiv = 1'b0; AbsoluterSprung = 1'b0;
      end
    end
    Weiter = 1'b0; SprungAktiv = 1'b0; AbsoluterSprung = 1'b0;
    chk("dekodier_gesehen", 32'(seen), 32'd1);
    if (seen) begin
      chk("instruktion", Instruktion, mem_word(exp_pc));
      if (exp_lat > 0) chk("latenz", 32'(n), 32'(exp_lat));
      if (exp_lesen >= 0) chk("lesezyklen", 32'(lesen_n), 32'(exp_lesen));
      @(negedge Clock);
      chk("dekodier_einmal", 32'(DekodierSignal), 32'd0);
      chk("befehlszaehler", BefehlsZaehler, exp_pc);
      chk("rueckkehr", RueckkehrAdresse, exp_pc + 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: observed no end, expected finish");
    $fatal(1, "timeout");
  end

  logic [31:0] model_pc;
  logic [31:0] ziel;
  logic [31:0] regw;
  logic [25:0] off;
  int          w, idle, kind, lat, les, found;
  bit          wt, q;

  initial begin
    // Reset state
    repeat (3) @(negedge Clock);
    chk("reset_lesen", 32'(SpeicherLesen), 32'd0);
    chk("reset_dekodier", 32'(DekodierSignal), 32'd0);
    chk("reset_instruktion", Instruktion, 32'd0);
    chk("reset_bz", BefehlsZaehler, START);
    chk("reset_rueckkehr", RueckkehrAdresse, START + 32'd1);
    Reset = 1'b0;
    #1;
    chk("start_lesen", 32'(SpeicherLesen), 32'd1);
    chk("start_adresse", SpeicherAdresse, START);
    model_pc = START;
    wait_decode(model_pc, 1, -1, 1'b0);

    // Zero-wait sequential words, then two wait states
    for (int i = 0; i < 2; i++) begin
      befehl(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      model_pc = model_pc + 32'd1;
      wait_decode(model_pc, lat_seq(0), les_cnt(0), 1'b0);
    end
    wait_cfg = 2;
    befehl(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    model_pc = model_pc + 32'd1;
    wait_decode(model_pc, 0, les_cnt(2), 1'b0);
    wait_cfg = 0;
    @(negedge Clock);

    // Absolute to 10, relative -4 from 10, absolute 10 then 0x100
    befehl(1'b0, 1'b1, 1'b0, 1'b1, '0, 32'd10);
    model_pc = 32'd10;
    wait_decode(model_pc, lat_jmp(0), les_cnt(0), 1'b0);
    befehl(1'b0, 1'b1, 1'b1, 1'b0, 26'h3FF_FFFC, '0);
    model_pc = 32'd6;
    wait_decode(model_pc, lat_jmp(0), les_cnt(0), 1'b0);
    befehl(1'b0, 1'b1, 1'b0, 1'b1, '0, 32'd10);
    model_pc = 32'd10;
    wait_decode(model_pc, lat_jmp(0), les_cnt(0), 1'b0);
    befehl(1'b0, 1'b1, 1'b0, 1'b1, '0, 32'h100);
    model_pc = 32'h100;
    wait_decode(model_pc, lat_jmp(0), les_cnt(0), 1'b0);

    // Jump beats Weiter; unqualified or doubly qualified jump acts as Weiter
    befehl(1'b1, 1'b1, 1'b1, 1'b0, 26'd5, '0);
    model_pc = 32'h105;
    wait_decode(model_pc, lat_jmp(0), les_cnt(0), 1'b0);
    befehl(1'b0, 1'b1, 1'b0, 1'b0, 26'd9, 32'h999);
    model_pc = 32'h106;
    wait_decode(model_pc, lat_seq(0), les_cnt(0), 1'b0);
    befehl(1'b0, 1'b1, 1'b1, 1'b1, 26'd9, 32'h999);
    model_pc = 32'h107;
    wait_decode(model_pc, lat_seq(0), les_cnt(0), 1'b0);

    // Reset while a read is pending
    wait_cfg = 5;
    befehl(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    found = 0;
    for (int i = 0; i < 10 && found == 0; i++) begin
      @(negedge Clock);
      if (SpeicherLesen === 1'b1 && DekodierSignal === 1'b0) found = 1;
    end
    chk("reset_anfrage_offen", 32'(found), 32'd1);
    Reset = 1'b1;
    #1;
    chk("reset_lesen_sofort", 32'(SpeicherLesen), 32'd0);
    @(negedge Clock);
    chk("reset_lesen_folge", 32'(SpeicherLesen), 32'd0);
    chk("reset_bz_start", BefehlsZaehler, START);
    chk("reset_instr_null", Instruktion, 32'd0);
    wait_cfg = 0;
    Reset = 1'b0;
    #1;
    chk("neustart_adresse", SpeicherAdresse, START);
    model_pc = START;
    wait_decode(model_pc, 1, -1, 1'b0);

    // PC wrap at the top of the address space
    befehl(1'b0, 1'b1, 1'b0, 1'b1, '0, 32'hFFFF_FFFF);
    model_pc = 32'hFFFF_FFFF;
    wait_decode(model_pc, lat_jmp(0), les_cnt(0), 1'b0);
    befehl(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
    model_pc = 32'd0;
    wait_decode(model_pc, lat_seq(0), les_cnt(0), 1'b0);

`ifdef BEFEHLSABRUF_VORHOLEN_EN
    // Back-to-back sequential stream and a jump over a pending speculative read
    for (int i = 0; i < 4; i++) begin
      befehl(1'b1, 1'b0, 1'b0, 1'b0, '0, '0);
      model_pc = model_pc + 32'd1;
      wait_decode(model_pc, 1, -1, 1'b0);
    end
    wait_cfg = 3;
    chk("spek_lesen", 32'(SpeicherLesen), 32'd1);
    chk("spek_adresse", SpeicherAdresse, model_pc + 32'd1);
    ziel = model_pc + 32'd1;
    befehl(1'b0, 1'b1, 1'b0, 1'b1, '0, 32'h200);
    @(negedge Clock);
    chk("verwerfen_lesen", 32'(SpeicherLesen), 32'd1);
    chk("verwerfen_adresse", SpeicherAdresse, ziel);
    model_pc = 32'h200;
    wait_decode(model_pc, 0, -1, 1'b0);
    wait_cfg = 0;
`endif

    // Randomized command stream against the architectural PC model
    for (int i = 0; i < 40; i++) begin
      w    = $urandom_range(0, 3);
      idle = $urandom_range(0, 2);
      kind = $urandom_range(0, 4);
      off  = 26'($urandom_range(0, 200)) - 26'd100;
      regw = $urandom();
      wt   = 1'($urandom_range(0, 1));
      q    = 1'($urandom_range(0, 1));
      repeat (idle) @(negedge Clock);
      wait_cfg = w;
      case (kind)
        0, 1: begin
          befehl(1'b1, 1'b0, 1'b0, 1'b0, off, regw);
          ziel = model_pc + 32'd1; lat = lat_seq(w); les = les_cnt(w);
        end
        2: begin
          befehl(wt, 1'b1, 1'b1, 1'b0, off, regw);
          ziel = model_pc + 32'($signed(off)); lat = lat_jmp(w); les = les_cnt(w);
        end
        3: begin
          befehl(wt, 1'b1, 1'b0, 1'b1, off, regw);
          ziel = regw; lat = lat_jmp(w); les = les_cnt(w);
        end
        default: begin
          befehl(wt, 1'b1, q, q, off, regw);
          ziel = model_pc + 32'd1; lat = lat_seq(w); les = les_cnt(w);
        end
      endcase
      model_pc = ziel;
      wait_decode(model_pc, lat, les, 1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
